// File: rtl/clock_time_controller_if.sv
// ---------------------------------------------------------------------------
// clock_time_controller_if
//   Bundles the tick/button/alarm inputs and the registered time/status
//   outputs of clock_time_controller.
//   master : the side driving tick, buttons and alarm settings
//            (prescaler, debouncers, alarm registers).
//   slave  : the controller itself.
//   Inputs  : tick, mode_btn, inc_btn, alarm_on, alarm_hour_tens/units,
//             alarm_min_tens/units, alarm_pm
//   Outputs : sec/min/hour BCD digits, pm, set_hr, set_min, chime, alarm_ring
// ---------------------------------------------------------------------------
interface clock_time_controller_if;
    logic       tick;
    logic       mode_btn;
    logic       inc_btn;
    logic       alarm_on;
    logic [1:0] alarm_hour_tens;
    logic [3:0] alarm_hour_units;
    logic [3:0] alarm_min_tens;
    logic [3:0] alarm_min_units;
    logic       alarm_pm;

    logic [3:0] sec_units;
    logic [3:0] sec_tens;
    logic [3:0] min_units;
    logic [3:0] min_tens;
    logic [3:0] hour_units;
    logic [1:0] hour_tens;
    logic       pm;
    logic       set_hr;
    logic       set_min;
    logic       chime;
    logic       alarm_ring;

    modport master (
        output tick, mode_btn, inc_btn, alarm_on, alarm_hour_tens,
               alarm_hour_units, alarm_min_tens, alarm_min_units, alarm_pm,
        input  sec_units, sec_tens, min_units, min_tens, hour_units,
               hour_tens, pm, set_hr, set_min, chime, alarm_ring
    );

    modport slave (
        input  tick, mode_btn, inc_btn, alarm_on, alarm_hour_tens,
               alarm_hour_units, alarm_min_tens, alarm_min_units, alarm_pm,
        output sec_units, sec_tens, min_units, min_tens, hour_units,
               hour_tens, pm, set_hr, set_min, chime, alarm_ring
    );
endinterface

// File: rtl/clock_time_controller.sv
// ---------------------------------------------------------------------------
// clock_time_controller
//   12-hour BCD timekeeper with a RUN / SET_HR / SET_MIN mode FSM.
//   Time advances on the 1 Hz tick in RUN; in the SET states inc_btn bumps
//   the selected field and ticks only feed the auto-return timeout.
//   Ports:
//     clk    : system clock, rising edge
//     reset  : asynchronous active-low reset
//     bus    : clock_time_controller_if.slave (tick, buttons, alarm inputs,
//              registered time digits and status flags)
//   Optional feature macro: ALARM_EN  (alarm compare and alarm_ring output;
//   when undefined alarm_ring is tied low and alarm inputs are ignored)
// ---------------------------------------------------------------------------
module clock_time_controller #(
    parameter int TIMEOUT_TICKS = 30,
    parameter int TO_W          = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    clock_time_controller_if.slave  bus
);

    // Bit 0 drives set_hr, bit 1 drives set_min directly from the register.
    localparam logic [1:0] S_RUN = 2'b00;
    localparam logic [1:0] S_HR  = 2'b01;
    localparam logic [1:0] S_MIN = 2'b10;

    logic [3:0]      sec_u_q, sec_u_d, sec_t_q, sec_t_d;
    logic [3:0]      min_u_q, min_u_d, min_t_q, min_t_d;
    logic [3:0]      hr_u_q, hr_u_d;
    logic [1:0]      hr_t_q, hr_t_d;
    logic            pm_q, pm_d;
    logic [1:0]      state_q, state_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            chime_q, chime_d;
    logic            ring_q, ring_d;

    // Field increments, computed once and shared by RUN and the SET states.
    logic       sec_wrap, min_wrap;
    logic [3:0] sec_nu, sec_nt, min_nu, min_nt;
    logic       hr_valid;
    logic [3:0] hr_nu;
    logic [1:0] hr_nt;
    logic       hr_npm;

    assign sec_wrap = (sec_u_q >= 4'd9) && (sec_t_q >= 4'd5);
    assign sec_nu   = (sec_u_q >= 4'd9) ? 4'd0 : sec_u_q + 4'd1;
    assign sec_nt   = (sec_u_q < 4'd9) ? sec_t_q :
                      (sec_t_q >= 4'd5) ? 4'd0 : sec_t_q + 4'd1;
    assign min_wrap = (min_u_q >= 4'd9) && (min_t_q >= 4'd5);
    assign min_nu   = (min_u_q >= 4'd9) ? 4'd0 : min_u_q + 4'd1;
    assign min_nt   = (min_u_q < 4'd9) ? min_t_q :
                      (min_t_q >= 4'd5) ? 4'd0 : min_t_q + 4'd1;

    assign hr_valid = ((hr_t_q == 2'd0) && (hr_u_q >= 4'd1) && (hr_u_q <= 4'd9)) ||
                      ((hr_t_q == 2'd1) && (hr_u_q <= 4'd2));

    // 12-hour step: 11->12 toggles pm, 12->01, anything illegal snaps to 12.
    always_comb begin
        hr_nt  = hr_t_q;
        hr_nu  = hr_u_q;
        hr_npm = pm_q;
        if (!hr_valid) begin
            hr_nt = 2'd1;
            hr_nu = 4'd2;
        end else if (hr_t_q == 2'd1 && hr_u_q == 4'd1) begin
            hr_nu  = 4'd2;
            hr_npm = ~pm_q;
        end else if (hr_t_q == 2'd1 && hr_u_q == 4'd2) begin
            hr_nt = 2'd0;
            hr_nu = 4'd1;
        end else if (hr_u_q == 4'd9) begin
            hr_nt = 2'd1;
            hr_nu = 4'd0;
        end else begin
            hr_nu = hr_u_q + 4'd1;
        end
    end

    logic btn_any, consume, mode_e, inc_e, timeout;

    assign btn_any = bus.mode_btn | bus.inc_btn;
`ifdef ALARM_EN
    // A button press that silences a ringing alarm does nothing else.
    assign consume = ring_q & btn_any;
`else
    assign consume = 1'b0;
    logic unused_alarm;
    assign unused_alarm = ^{bus.alarm_on, bus.alarm_hour_tens, bus.alarm_hour_units,
                            bus.alarm_min_tens, bus.alarm_min_units, bus.alarm_pm};
`endif
    assign mode_e  = bus.mode_btn & ~consume;
    assign inc_e   = bus.inc_btn & ~bus.mode_btn & ~consume;
    assign timeout = (TIMEOUT_TICKS != 0) && (to_q == TO_W'(TIMEOUT_TICKS));

    always_comb begin
        sec_u_d = sec_u_q;
        sec_t_d = sec_t_q;
        min_u_d = min_u_q;
        min_t_d = min_t_q;
        hr_u_d  = hr_u_q;
        hr_t_d  = hr_t_q;
        pm_d    = pm_q;
        state_d = state_q;
        to_d    = to_q;
        chime_d = 1'b0;
        ring_d  = 1'b0;

        case (state_q)
            S_RUN: begin
                to_d = '0;
                if (bus.tick) begin
                    sec_u_d = sec_nu;
                    sec_t_d = sec_nt;
                    if (sec_wrap) begin
                        min_u_d = min_nu;
                        min_t_d = min_nt;
                        if (min_wrap)
                            chime_d = 1'b1;
                    end
                    // An illegal hour is repaired on any tick, not just on carry.
                    if ((sec_wrap && min_wrap) || !hr_valid) begin
                        hr_u_d = hr_nu;
                        hr_t_d = hr_nt;
                        pm_d   = hr_npm;
                    end
                end
                if (mode_e)
                    state_d = S_HR;
            end
            S_HR: begin
                if (mode_e) begin
                    state_d = S_MIN;
                    to_d    = '0;
                end else if (inc_e) begin
                    hr_u_d = hr_nu;
                    hr_t_d = hr_nt;
                    pm_d   = hr_npm;
                    to_d   = '0;
                end else if (timeout) begin
                    state_d = S_RUN;
                    to_d    = '0;
                end else if (bus.tick) begin
                    to_d = to_q + 1'b1;
                end
            end
            S_MIN: begin
                if (mode_e || (!inc_e && timeout)) begin
                    state_d = S_RUN;
                    sec_u_d = 4'd0;
                    sec_t_d = 4'd0;
                    to_d    = '0;
                end else if (inc_e) begin
                    min_u_d = min_nu;
                    min_t_d = min_nt;
                    to_d    = '0;
                end else if (bus.tick) begin
                    to_d = to_q + 1'b1;
                end
            end
            default: begin
                state_d = S_RUN;
                to_d    = '0;
            end
        endcase

`ifdef ALARM_EN
        // Match is taken on the tick that lands on hh:mm:00; a button in the
        // same cycle suppresses it so the press is never silently swallowed.
        ring_d = bus.alarm_on &
                 ((state_q == S_RUN && bus.tick && !btn_any &&
                   sec_u_d == 4'd0 && sec_t_d == 4'd0 &&
                   min_u_d == bus.alarm_min_units && min_t_d == bus.alarm_min_tens &&
                   hr_u_d == bus.alarm_hour_units && hr_t_d == bus.alarm_hour_tens &&
                   pm_d == bus.alarm_pm) ||
                  (ring_q && !btn_any));
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sec_u_q <= 4'd0;
            sec_t_q <= 4'd0;
            min_u_q <= 4'd0;
            min_t_q <= 4'd0;
            hr_u_q  <= 4'd2;
            hr_t_q  <= 2'd1;
            pm_q    <= 1'b0;
            state_q <= S_RUN;
            to_q    <= '0;
            chime_q <= 1'b0;
            ring_q  <= 1'b0;
        end else begin
            sec_u_q <= sec_u_d;
            sec_t_q <= sec_t_d;
            min_u_q <= min_u_d;
            min_t_q <= min_t_d;
            hr_u_q  <= hr_u_d;
            hr_t_q  <= hr_t_d;
            pm_q    <= pm_d;
            state_q <= state_d;
            to_q    <= to_d;
            chime_q <= chime_d;
            ring_q  <= ring_d;
        end
    end

    assign bus.sec_units  = sec_u_q;
    assign bus.sec_tens   = sec_t_q;
    assign bus.min_units  = min_u_q;
    assign bus.min_tens   = min_t_q;
    assign bus.hour_units = hr_u_q;
    assign bus.hour_tens  = hr_t_q;
    assign bus.pm         = pm_q;
    assign bus.set_hr     = state_q[0];
    assign bus.set_min    = state_q[1];
    assign bus.chime      = chime_q;
    assign bus.alarm_ring = ring_q;

endmodule

// File: tb/tb_clock_time_controller.sv
// ---------------------------------------------------------------------------
// tb_clock_time_controller
//   Directed scenarios plus a randomized run, every cycle compared against a
//   reference model that keeps time as plain integers (hour 1-12, minute,
//   second, pm) and the mode as a small integer.
// ---------------------------------------------------------------------------
module tb_clock_time_controller;

    localparam int TO = 30;
`ifdef ALARM_EN
    localparam bit ALARM = 1'b1;
`else
    localparam bit ALARM = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    clock_time_controller_if bus();

    clock_time_controller #(.TIMEOUT_TICKS(TO), .TO_W(6)) u_dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int m_h, m_m, m_s, m_st, m_to;   // m_st: 0 run, 1 set hour, 2 set minute
    bit m_pm, m_chime, m_ring;

    function automatic void model_reset();
        m_h = 12; m_m = 0; m_s = 0; m_pm = 0;
        m_st = 0; m_to = 0; m_chime = 0; m_ring = 0;
    endfunction

    function automatic void hour_up();
        if (m_h == 11) begin m_h = 12; m_pm = !m_pm; end
        else if (m_h == 12) m_h = 1;
        else m_h = m_h + 1;
    endfunction

    function automatic void model_step(bit tk, bit mb, bit ib);
        bit any = mb | ib;
        bit tk_run = 0;
        int ah, am;
        m_chime = 0;
        if (ALARM && m_ring && any) begin mb = 0; ib = 0; end
        case (m_st)
            0: begin
                if (tk) begin
                    tk_run = 1;
                    m_s++;
                    if (m_s == 60) begin
                        m_s = 0; m_m++;
                        if (m_m == 60) begin m_m = 0; m_chime = 1; hour_up(); end
                    end
                end
                if (mb) begin m_st = 1; m_to = 0; end
            end
            1: begin
                if (mb) begin m_st = 2; m_to = 0; end
                else if (ib) begin hour_up(); m_to = 0; end
                else if (m_to == TO) begin m_st = 0; m_to = 0; end
                else if (tk) m_to++;
            end
            default: begin
                if (mb) begin m_st = 0; m_s = 0; m_to = 0; end
                else if (ib) begin m_m = (m_m + 1) % 60; m_to = 0; end
                else if (m_to == TO) begin m_st = 0; m_s = 0; m_to = 0; end
                else if (tk) m_to++;
            end
        endcase
        ah = int'(bus.alarm_hour_tens) * 10 + int'(bus.alarm_hour_units);
        am = int'(bus.alarm_min_tens) * 10 + int'(bus.alarm_min_units);
        if (ALARM)
            m_ring = bus.alarm_on &&
                     ((tk_run && !any && m_s == 0 && m_m == am && m_h == ah && m_pm == bus.alarm_pm) ||
                      (m_ring && !any));
        else
            m_ring = 0;
    endfunction

    function automatic logic [21:0] bcd_time(int h, int m, int s);
        bcd_time = {2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [21:0] dut_time();
        dut_time = {bus.hour_tens, bus.hour_units, bus.min_tens, bus.min_units,
                    bus.sec_tens, bus.sec_units};
    endfunction

    task automatic compare();
        chk("time", 32'(dut_time()), 32'(bcd_time(m_h, m_m, m_s)));
        chk("flags", 32'({bus.pm, bus.set_hr, bus.set_min, bus.chime, bus.alarm_ring}),
            32'({m_pm, m_st == 1, m_st == 2, m_chime, m_ring}));
    endtask

    task automatic step(input bit tk, input bit mb, input bit ib);
        bus.tick = tk; bus.mode_btn = mb; bus.inc_btn = ib;
        @(posedge clk);
        model_step(tk, mb, ib);
        #1;
        compare();
        bus.tick = 1'b0; bus.mode_btn = 1'b0; bus.inc_btn = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        compare();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int chimes;

    initial begin
        bus.tick = 0; bus.mode_btn = 0; bus.inc_btn = 0;
        bus.alarm_on = 0; bus.alarm_hour_tens = 0; bus.alarm_hour_units = 0;
        bus.alarm_min_tens = 0; bus.alarm_min_units = 0; bus.alarm_pm = 0;
        model_reset();
        #22;
        chk("reset_time", 32'(dut_time()), 32'(bcd_time(12, 0, 0)));
        chk("reset_flags", 32'({bus.pm, bus.set_hr, bus.set_min, bus.chime, bus.alarm_ring}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // One hour of ticks: exactly one chime, on the final step.
        chimes = 0;
        for (int i = 0; i < 3600; i++) begin
            step(1, 0, 0);
            chimes += int'(bus.chime);
        end
        chk("hour_time", 32'(dut_time()), 32'(bcd_time(1, 0, 0)));
        chk("hour_chime_cnt", 32'(chimes), 32'd1);
        chk("hour_chime_last", 32'(bus.chime), 32'd1);
        chk("hour_pm", 32'(bus.pm), 32'd0);

        // Set 11:59 PM, run to 11:59:58, then midnight rollover.
        step(0, 1, 0);
        for (int i = 0; i < 22; i++) step(0, 0, 1);
        chk("set_11pm_pm", 32'(bus.pm), 32'd1);
        step(0, 1, 0);
        for (int i = 0; i < 59; i++) step(0, 0, 1);
        step(0, 1, 0);
        for (int i = 0; i < 58; i++) step(1, 0, 0);
        chk("pre_midnight", 32'(dut_time()), 32'(bcd_time(11, 59, 58)));
        step(1, 0, 0);
        step(1, 0, 0);
        chk("midnight_time", 32'(dut_time()), 32'(bcd_time(12, 0, 0)));
        chk("midnight_pm", 32'(bus.pm), 32'd0);
        chk("midnight_chime", 32'(bus.chime), 32'd1);
        step(0, 0, 0);
        chk("chime_one_cycle", 32'(bus.chime), 32'd0);

        // mode, inc x3, mode, inc x61, mode -> 03:01:00.
        step(0, 1, 0);
        chk("set_hr_flag", 32'({bus.set_hr, bus.set_min}), 32'b10);
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        step(0, 1, 0);
        chk("set_min_flag", 32'({bus.set_hr, bus.set_min}), 32'b01);
        for (int i = 0; i < 61; i++) step(0, 0, 1);
        step(0, 1, 0);
        chk("set_result", 32'(dut_time()), 32'(bcd_time(3, 1, 0)));
        chk("set_run_flags", 32'({bus.set_hr, bus.set_min}), 32'b00);

        // Timeout out of SET_HR, then mode+inc together.
        step(0, 1, 0);
        for (int i = 0; i < 30; i++) step(1, 0, 0);
        chk("to_still_set", 32'(bus.set_hr), 32'd1);
        step(0, 0, 0);
        chk("to_back_run", 32'(bus.set_hr), 32'd0);
        chk("to_time_kept", 32'(dut_time()), 32'(bcd_time(3, 1, 0)));
        step(0, 1, 1);
        chk("mode_wins", 32'({bus.set_hr, bus.hour_tens, bus.hour_units}), 32'({1'b1, 2'd0, 4'd3}));

        // Reset in the middle of SET_MIN takes effect without a clock edge.
        step(0, 1, 0);
        step(0, 0, 1);
        @(negedge clk);
        #2;
        do_reset();
        chk("midreset_time", 32'(dut_time()), 32'(bcd_time(12, 0, 0)));
        chk("midreset_state", 32'({bus.pm, bus.set_hr, bus.set_min}), 32'd0);

        // Alarm at 12:01 AM.
        bus.alarm_on = 1; bus.alarm_hour_tens = 2'd1; bus.alarm_hour_units = 4'd2;
        bus.alarm_min_tens = 4'd0; bus.alarm_min_units = 4'd1; bus.alarm_pm = 1'b0;
        for (int i = 0; i < 60; i++) step(1, 0, 0);
        chk("alarm_time", 32'(dut_time()), 32'(bcd_time(12, 1, 0)));
        chk("alarm_ring", 32'(bus.alarm_ring), 32'(ALARM));
        step(0, 0, 1);
        chk("alarm_clear", 32'(bus.alarm_ring), 32'd0);
        chk("alarm_hour_kept", 32'({bus.hour_tens, bus.hour_units}), 32'({2'd1, 4'd2}));

        // Randomized traffic with tick bursts and sparse buttons.
        for (int i = 0; i < 5000; i++) begin
            if ((i % 500) == 0) begin
                bus.alarm_on = 1'($urandom_range(0, 1));
                bus.alarm_pm = 1'($urandom_range(0, 1));
                bus.alarm_hour_tens = 2'($urandom_range(0, 1));
                bus.alarm_hour_units = 4'($urandom_range(0, 2));
                bus.alarm_min_tens = 4'($urandom_range(0, 5));
                bus.alarm_min_units = 4'($urandom_range(0, 9));
            end
            step(1'($urandom_range(0, 1)),
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 19) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
